// File: rtl/gtech_arb8_rr.sv
`default_nettype none
// ============================================================================
// Module   : gtech_arb8_rr
// Purpose  : Eight-way round-robin arbiter with registered one-hot grant,
//            owner release/drop handling and optional hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module gtech_arb8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       CP,
    input  logic       RN,
    input  logic [7:0] REQ,
    input  logic [7:0] DONE,
    output logic [7:0] GNT,
    output logic [2:0] GID,
    output logic       BUSY,
    output logic       NONE,
    output logic       TOUT
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_owned = 1'b1;
    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
    localparam logic [7:0] c_hcnt_max = 8'hFF;

    logic [0:0] r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hcnt;
    logic [7:0] r_gnt;
    logic [2:0] r_gid;
    logic       r_tout;
    logic       r_none;

    logic [0:0] w_state_nxt;
    logic [2:0] w_ptr_nxt;
    logic [7:0] w_hcnt_nxt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] w_gid_nxt;
    logic       w_tout_nxt;

    logic [2:0] w_arb_ptr;
    logic [2:0] w_idx;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_owned;
    logic       w_timeout;
    logic       w_release;

    assign w_owned   = (r_state == c_st_owned);
    assign w_timeout = w_owned && (MAX_HOLD != 0) && (r_hcnt == c_max_hold);
    assign w_release = w_owned && (DONE[r_gid] || !REQ[r_gid] || w_timeout);

    // A release re-arbitrates in the same edge starting just past the owner.
    assign w_arb_ptr = w_owned ? (r_gid + 3'd1) : r_ptr;

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_idx = w_arb_ptr + 3'(k);
            if (REQ[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hcnt_nxt  = r_hcnt;
        w_gnt_nxt   = r_gnt;
        w_gid_nxt   = r_gid;
        w_tout_nxt  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_gnt_nxt = 8'h00;
                if (w_found) begin
                    w_state_nxt = c_st_owned;
                    w_gnt_nxt   = 8'h01 << w_win;
                    w_gid_nxt   = w_win;
                    w_hcnt_nxt  = 8'd1;
                end
            end
            c_st_owned: begin
                if (w_release) begin
                    w_ptr_nxt  = r_gid + 3'd1;
                    w_tout_nxt = w_timeout;
                    if (w_found) begin
                        w_gnt_nxt  = 8'h01 << w_win;
                        w_gid_nxt  = w_win;
                        w_hcnt_nxt = 8'd1;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_gnt_nxt   = 8'h00;
                        w_hcnt_nxt  = 8'd0;
                    end
                end else if (r_hcnt != c_hcnt_max) begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_gnt_nxt   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (!RN) begin
            r_state <= c_st_idle;
            r_ptr   <= 3'd0;
            r_hcnt  <= 8'd0;
            r_gnt   <= 8'h00;
            r_gid   <= 3'd0;
            r_tout  <= 1'b0;
            r_none  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gid   <= w_gid_nxt;
            r_tout  <= w_tout_nxt;
            r_none  <= ~|REQ;
        end
    end

    assign GNT  = r_gnt;
    assign GID  = r_gid;
    assign BUSY = (r_state == c_st_owned);
    assign NONE = r_none;
    assign TOUT = r_tout;

endmodule
`default_nettype wire
